time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  Parametrised time-setting controller for the digital-clock datapath: edits hours, minutes and seconds as BCD digits.
//  Snapshots the running time on entry to set mode and steps the selected field up or down with wrap-around.
//  Auto-repeats on held buttons and signals commit to the counter chain on exit.
//  Sits between the debounced button inputs and the c60/c24 counter load ports; also drives display blinking.
// PARAMETERS
//  HOUR_MODE   24       24: hours 00..23; 12: hours 01..12 (any other value treated as 24)
//  HOLD_CYC    500      cycles a button is held after its first step before auto-repeat starts (>=2)
//  REPEAT_CYC  100      cycles between auto-repeat steps (>=1)
//  BLINK_CYC   250      half-period of blink output in cycles (>=1)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  cr         in   1  asynchronous active-low reset
//  set_mode   in   1  level; 1 = setting session active (synchronous, debounced)
//  sel_next   in   1  level button; each rising edge advances the selected field
//  btn_up     in   1  level button; step selected field +1
//  btn_dn     in   1  level button; step selected field -1
//  cur_time   in  24  running time {ht,hu,mt,mu,st,su}, 4-bit BCD each
//  bcd_su/st  out  4  edited seconds units/tens
//  bcd_mu/mt  out  4  edited minutes units/tens
//  bcd_hu/ht  out  4  edited hours units/tens
//  field      out  2  selected field: 0=MIN, 1=HOUR, 2=SEC
//  blink      out  1  display blank request for the selected field
//  load       out  1  one-cycle commit strobe; bcd_* valid on that cycle
// BEHAVIOUR
//  Reset: state IDLE; bcd_* = 00:00:00 (12-mode: 12:00:00); field=0; blink=0; load=0; repeat/blink counters 0.
//  All inputs are registered once for edge detection; a single registered edge acts on the cycle after it is sampled.
//  FSM IDLE->CAPTURE on set_mode 0->1.
//    CAPTURE (1 cycle): load cur_time into bcd_*; field=0 -> EDIT.
//    Validation: any field with a non-BCD digit or an out-of-range value (min/sec >59; hour outside the mode range) captures its reset value.
//  EDIT: set_mode 1->0 -> COMMIT. COMMIT (1 cycle): load=1 -> IDLE. bcd_* hold in IDLE.
//  sel_next rising edge in EDIT: field 0->1->2->0; resets the repeat counter and blink phase (blink=0).
//  Step rules; no carry or borrow between fields.
//    MIN/SEC: +1 wraps 59->00; -1 wraps 00->59.
//    HOUR 24: 23->00 up, 00->23 down. HOUR 12: 12->01 up, 01->12 down.
//  Press: up rising edge alone, or dn rising edge alone, gives one immediate step.
//  Auto-repeat: button still held HOLD_CYC cycles after that step -> a step every REPEAT_CYC cycles while held.
//  Simultaneous: btn_up and btn_dn both high -> no step; repeat counter cleared.
//  sel_next edge in the same cycle as a step: field change wins; the step is dropped.
//  Release of either button clears the repeat counter.
//  Buttons and sel_next are ignored outside EDIT.
//  blink: 0 outside EDIT; in EDIT toggles every BLINK_CYC cycles, with the first toggle to 1 at BLINK_CYC cycles after entry.
//    Held at 0 while any step is being issued, so the changing digit stays visible.
//  set_mode dropping during CAPTURE: CAPTURE still completes, then EDIT sees set_mode=0 -> COMMIT.
//  Reset mid-session: immediate return to reset values; no load pulse.
// TESTING
//  Reset, HOUR_MODE=12 -> bcd 12:00:00, field=0, load=0, blink=0; HOUR_MODE=24 -> 00:00:00.
//  cur_time=23:59:58, set_mode 0->1 -> bcd=23:59:58 after CAPTURE; one up pulse on MIN -> 23:00:58, hours unchanged.
//  Hold btn_up on HOUR (24-mode, start 22) with HOLD_CYC=4, REPEAT_CYC=2 -> 23 at press, 00 after 4 cycles, 01 after 2 more.
//  12-mode HOUR=01, one dn pulse -> 12; up pulse -> 01; cur_time hour 00 captured -> 12.
//  btn_up and btn_dn high together for 20 cycles -> no change; sel_next with btn_up edge -> field 0->1, no step.
//  set_mode 1->0 -> load=1 for exactly one cycle with the edited bcd_*; cr low mid-EDIT -> reset values, load stays 0.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Time-setting controller: snapshots the running time, edits one BCD field at a time
// with press/auto-repeat stepping, and strobes load to the counter chain on exit.
module time_set_ctrl #(
    parameter int HOUR_MODE  = 24,
    parameter int HOLD_CYC   = 500,
    parameter int REPEAT_CYC = 100,
    parameter int BLINK_CYC  = 250
) (
    input  logic        clk,
    input  logic        cr,
    input  logic        set_mode,
    input  logic        sel_next,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic [23:0] cur_time,
    output logic [3:0]  bcd_su,
    output logic [3:0]  bcd_st,
    output logic [3:0]  bcd_mu,
    output logic [3:0]  bcd_mt,
    output logic [3:0]  bcd_hu,
    output logic [3:0]  bcd_ht,
    output logic [1:0]  field,
    output logic        blink,
    output logic        load
);

    localparam bit IS12 = (HOUR_MODE == 12);
    localparam int RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int BW   = $clog2(BLINK_CYC + 1);

    localparam logic [RW-1:0] HOLD_N     = RW'(HOLD_CYC);
    localparam logic [RW-1:0] REPEAT_N   = RW'(REPEAT_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam logic [7:0]    HOUR_MIN   = IS12 ? 8'h01 : 8'h00;
    localparam logic [7:0]    HOUR_MAX   = IS12 ? 8'h12 : 8'h23;
    localparam logic [7:0]    HOUR_RST   = IS12 ? 8'h12 : 8'h00;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EDIT, S_COMMIT} state_e;
    typedef enum logic [1:0] {F_MIN = 2'd0, F_HOUR = 2'd1, F_SEC = 2'd2} field_e;

    state_e        state_q, state_d;
    field_e        field_q, field_d;
    logic          sm_q, sm_d, sm_p_q, sm_p_d;
    logic          sel_q, sel_d, sel_p_q, sel_p_d;
    logic          up_q, up_d, up_p_q, up_p_d;
    logic          dn_q, dn_d, dn_p_q, dn_p_d;
    logic [23:0]   cur_q, cur_d;
    logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_run_q, rep_run_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    logic          sel_rise, up_rise, dn_rise, step_req, step_up;

    function automatic logic [7:0] step60(input logic [7:0] v, input logic up);
        logic [3:0] t, u;
        t = v[7:4];
        u = v[3:0];
        if (up) begin
            if (u == 4'd9) begin
                u = 4'd0;
                t = (t == 4'd5) ? 4'd0 : t + 4'd1;
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (u == 4'd0) begin
                u = 4'd9;
                t = (t == 4'd0) ? 4'd5 : t - 4'd1;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    function automatic logic [7:0] step_hour(input logic [7:0] v, input logic up);
        logic [3:0] t, u;
        t = v[7:4];
        u = v[3:0];
        if (up) begin
            if (v == HOUR_MAX) return HOUR_MIN;
            if (u == 4'd9) begin
                u = 4'd0;
                t = t + 4'd1;
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (v == HOUR_MIN) return HOUR_MAX;
            if (u == 4'd0) begin
                u = 4'd9;
                t = t - 4'd1;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    function automatic logic ok60(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // BCD ordering matches numeric ordering once the units digit is a valid digit
    function automatic logic ok_hour(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v >= HOUR_MIN) && (v <= HOUR_MAX);
    endfunction

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        sm_d        = set_mode;
        sm_p_d      = sm_q;
        sel_d       = sel_next;
        sel_p_d     = sel_q;
        up_d        = btn_up;
        up_p_d      = up_q;
        dn_d        = btn_dn;
        dn_p_d      = dn_q;
        cur_d       = cur_time;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        rep_cnt_d   = rep_cnt_q;
        rep_run_d   = rep_run_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        sel_rise    = sel_q & ~sel_p_q;
        up_rise     = up_q & ~up_p_q;
        dn_rise     = dn_q & ~dn_p_q;
        step_req    = 1'b0;
        step_up     = up_q;

        case (state_q)
            S_IDLE: begin
                rep_cnt_d   = '0;
                rep_run_d   = 1'b0;
                blink_cnt_d = '0;
                blink_d     = 1'b0;
                if (sm_q && !sm_p_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                hour_d      = ok_hour(cur_q[23:16]) ? cur_q[23:16] : HOUR_RST;
                min_d       = ok60(cur_q[15:8]) ? cur_q[15:8] : 8'h00;
                sec_d       = ok60(cur_q[7:0]) ? cur_q[7:0] : 8'h00;
                field_d     = F_MIN;
                rep_cnt_d   = '0;
                rep_run_d   = 1'b0;
                blink_cnt_d = '0;
                blink_d     = 1'b0;
                state_d     = S_EDIT;
            end
            S_EDIT: begin
                if (!sm_q) begin
                    blink_cnt_d = '0;
                    blink_d     = 1'b0;
                    state_d     = S_COMMIT;
                end else if (sel_rise) begin
                    case (field_q)
                        F_MIN:   field_d = F_HOUR;
                        F_HOUR:  field_d = F_SEC;
                        default: field_d = F_MIN;
                    endcase
                    rep_cnt_d   = '0;
                    rep_run_d   = 1'b0;
                    blink_cnt_d = '0;
                    blink_d     = 1'b0;
                end else begin
                    if (up_q && dn_q) begin
                        rep_cnt_d = '0;
                        rep_run_d = 1'b0;
                    end else if (up_q || dn_q) begin
                        if (up_rise || dn_rise) begin
                            step_req  = 1'b1;
                            rep_cnt_d = RW'(1);
                            rep_run_d = 1'b0;
                        // a zero counter means no press armed the repeat for this hold
                        end else if (rep_cnt_q != '0) begin
                            if (rep_cnt_q == (rep_run_q ? REPEAT_N : HOLD_N)) begin
                                step_req  = 1'b1;
                                rep_cnt_d = RW'(1);
                                rep_run_d = 1'b1;
                            end else begin
                                rep_cnt_d = rep_cnt_q + RW'(1);
                            end
                        end
                    end else begin
                        rep_cnt_d = '0;
                        rep_run_d = 1'b0;
                    end

                    if (step_req || rep_cnt_q != '0) begin
                        blink_cnt_d = '0;
                        blink_d     = 1'b0;
                    end else if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end

                    if (step_req) begin
                        case (field_q)
                            F_MIN:   min_d  = step60(min_q, step_up);
                            F_HOUR:  hour_d = step_hour(hour_q, step_up);
                            default: sec_d  = step60(sec_q, step_up);
                        endcase
                    end
                end
            end
            default: begin
                rep_cnt_d   = '0;
                rep_run_d   = 1'b0;
                blink_cnt_d = '0;
                blink_d     = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            state_q     <= S_IDLE;
            field_q     <= F_MIN;
            sm_q        <= 1'b0;
            sm_p_q      <= 1'b0;
            sel_q       <= 1'b0;
            sel_p_q     <= 1'b0;
            up_q        <= 1'b0;
            up_p_q      <= 1'b0;
            dn_q        <= 1'b0;
            dn_p_q      <= 1'b0;
            cur_q       <= '0;
            hour_q      <= HOUR_RST;
            min_q       <= '0;
            sec_q       <= '0;
            rep_cnt_q   <= '0;
            rep_run_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            sm_q        <= sm_d;
            sm_p_q      <= sm_p_d;
            sel_q       <= sel_d;
            sel_p_q     <= sel_p_d;
            up_q        <= up_d;
            up_p_q      <= up_p_d;
            dn_q        <= dn_d;
            dn_p_q      <= dn_p_d;
            cur_q       <= cur_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_run_q   <= rep_run_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign {bcd_ht, bcd_hu} = hour_q;
    assign {bcd_mt, bcd_mu} = min_q;
    assign {bcd_st, bcd_su} = sec_q;
    assign field            = field_q;
    assign blink            = blink_q;
    assign load             = (state_q == S_COMMIT);

endmodule
